// File: rtl/vospi_frame_parser.sv
// VoSPI packet parser: 32-bit raw byte stream in, 16-bit pixel AXI-Stream out.
// Optional CRC-16 packet check is built only when VOSPI_CRC_CHECK_EN is defined.
module vospi_frame_parser #(
  parameter int unsigned LINE_PIXELS = 80,
  parameter int unsigned FRAME_LINES = 60,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [15:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 frame_done,
  output logic                 seq_err,
  output logic [CNT_WIDTH-1:0] discard_cnt,
  output logic [5:0]           line_num
`ifdef VOSPI_CRC_CHECK_EN
  ,
  output logic                 crc_err
`endif
);

  localparam int unsigned WORDS = LINE_PIXELS / 2;
  localparam int unsigned WC_W  = $clog2(WORDS + 1);
  localparam int unsigned PC_W  = $clog2(LINE_PIXELS);

  typedef enum logic [1:0] {HUNT, HEADER, PIXELS, DROP} state_e;

  state_e               state_q, state_d;
  logic                 drop_ret_q, drop_ret_d;
  logic                 run_q;
  logic [WC_W-1:0]      word_cnt_q;
  logic [PC_W-1:0]      pix_cnt_q;
  logic [11:0]          line_cnt_q;
  logic [31:0]          hold_q;
  logic [1:0]           hold_cnt_q;
  logic                 frame_done_q, seq_err_q;
  logic [CNT_WIDTH-1:0] disc_q;

  logic        s_fire, m_fire, hdr_word, is_disc, pn_match, last_word, tlast_fire;
  logic [11:0] pn;

  assign s_fire     = s_axis_tvalid && s_axis_tready;
  assign m_fire     = m_axis_tvalid && m_axis_tready;
  assign hdr_word   = s_fire && (word_cnt_q == '0);
  assign pn         = {s_axis_tdata[3:0], s_axis_tdata[15:8]};
  assign is_disc    = (s_axis_tdata[3:0] == 4'hF);
  assign pn_match   = (pn == line_cnt_q);
  assign last_word  = (word_cnt_q == WC_W'(WORDS));
  assign tlast_fire = m_fire && m_axis_tlast;

`ifdef VOSPI_CRC_CHECK_EN
  logic [15:0] crc_q, crc_hdr_q, crc_nxt;
  logic [31:0] crc_in;
  logic        crc_err_q, abort_q, crc_bad;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic [7:0]  d;
    r = c;
    d = b;
    for (int unsigned i = 0; i < 8; i++) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[7]) ? 16'h1021 : 16'h0000);
      d = {d[6:0], 1'b0};
    end
    return r;
  endfunction

  // Header word enters the CRC with id[15:12] and the CRC field zeroed.
  always_comb begin
    crc_in  = (word_cnt_q == '0) ? {16'h0000, s_axis_tdata[15:8], 4'h0, s_axis_tdata[3:0]}
                                 : s_axis_tdata;
    crc_nxt = (word_cnt_q == '0) ? 16'h0000 : crc_q;
    crc_nxt = crc_byte(crc_nxt, crc_in[7:0]);
    crc_nxt = crc_byte(crc_nxt, crc_in[15:8]);
    crc_nxt = crc_byte(crc_nxt, crc_in[23:16]);
    crc_nxt = crc_byte(crc_nxt, crc_in[31:24]);
  end

  assign crc_bad = (state_q == PIXELS) && s_fire && last_word && (crc_nxt != crc_hdr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= '0;
      crc_hdr_q <= '0;
      crc_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      crc_err_q <= crc_bad;
      if (s_fire) crc_q <= crc_nxt;
      if (hdr_word) crc_hdr_q <= {s_axis_tdata[23:16], s_axis_tdata[31:24]};
      if (state_d == HUNT) abort_q <= 1'b0;
      else if (crc_bad)    abort_q <= 1'b1;
    end
  end

  assign crc_err = crc_err_q;
`else
  logic abort_q;
  assign abort_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      drop_ret_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_ret_q <= drop_ret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drop_ret_d = drop_ret_q;
    if (!en) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT: if (hdr_word) begin
          drop_ret_d = 1'b0;
          state_d    = (!is_disc && pn == 12'd0) ? PIXELS : DROP;
        end
        HEADER: if (abort_q) begin
          if (hold_cnt_q == 2'd0) state_d = HUNT;
        end else if (hdr_word) begin
          drop_ret_d = is_disc;
          state_d    = (!is_disc && pn_match) ? PIXELS : DROP;
        end
        PIXELS: if (s_fire && last_word) state_d = HEADER;
        DROP:   if (s_fire && last_word) state_d = drop_ret_q ? HEADER : HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      HUNT:    s_axis_tready = (hold_cnt_q == 2'd0);
      HEADER:  s_axis_tready = (hold_cnt_q == 2'd0) && !abort_q;
      PIXELS:  s_axis_tready = (hold_cnt_q == 2'd0) || ((hold_cnt_q == 2'd1) && m_axis_tready);
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
    s_axis_tready = s_axis_tready && run_q;
    m_axis_tvalid = (hold_cnt_q != 2'd0);
    m_axis_tdata  = hold_q[15:0];
    m_axis_tlast  = m_axis_tvalid && (pix_cnt_q == PC_W'(LINE_PIXELS - 1));
    m_axis_tuser  = m_axis_tvalid && (line_cnt_q == 12'd0) && (pix_cnt_q == '0);
    frame_done    = frame_done_q;
    seq_err       = seq_err_q;
    discard_cnt   = disc_q;
    line_num      = line_cnt_q[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      word_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      hold_q       <= '0;
      hold_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      disc_q       <= '0;
    end else begin
      run_q        <= 1'b1;
      frame_done_q <= tlast_fire && (line_cnt_q == 12'(FRAME_LINES - 1)) && !abort_q;
      seq_err_q    <= en && (state_q == HEADER) && hdr_word && !is_disc && !pn_match && !abort_q;
      if (s_fire) word_cnt_q <= last_word ? '0 : word_cnt_q + WC_W'(1);
      if (en && (state_q == HUNT || state_q == HEADER) && hdr_word && is_disc && !(&disc_q))
        disc_q <= disc_q + CNT_WIDTH'(1);
      if (en && state_q == HUNT && hdr_word && !is_disc && pn == 12'd0)
        line_cnt_q <= '0;
      else if (tlast_fire)
        line_cnt_q <= (line_cnt_q == 12'(FRAME_LINES - 1) || abort_q) ? '0 : line_cnt_q + 12'd1;
      if (state_q == HUNT) begin
        // An offered pixel finishes its handshake before the hold register is emptied.
        if (hold_cnt_q == 2'd0 || m_fire) begin
          hold_cnt_q <= '0;
          pix_cnt_q  <= '0;
        end
      end else begin
        if (s_fire && state_q == PIXELS) begin
          hold_q     <= {s_axis_tdata[23:16], s_axis_tdata[31:24],
                         s_axis_tdata[7:0],   s_axis_tdata[15:8]};
          hold_cnt_q <= 2'd2;
        end else if (m_fire) begin
          hold_q[15:0] <= hold_q[31:16];
          hold_cnt_q   <= hold_cnt_q - 2'd1;
        end
        if (m_fire) pix_cnt_q <= (pix_cnt_q == PC_W'(LINE_PIXELS - 1)) ? '0 : pix_cnt_q + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vospi_frame_parser.sv
// Randomised bench for vospi_frame_parser: packet-level reference model of the
// line-sequence rules feeds an expected pixel queue compared at the output.
module tb_vospi_frame_parser;

  localparam int unsigned LP = 80;
  localparam int unsigned FL = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic        frame_done, seq_err;
  logic [15:0] discard_cnt;
  logic [5:0]  line_num;

  always #5 clk = ~clk;

  vospi_frame_parser #(.LINE_PIXELS(LP), .FRAME_LINES(FL), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_done(frame_done), .seq_err(seq_err), .discard_cnt(discard_cnt), .line_num(line_num)
  );

  int unsigned n_checks = 0, n_errors = 0;
  logic [31:0] src_q[$];
  logic [17:0] exp_q[$];
  int unsigned tmode = 0, gap_pct = 20;
  int unsigned n_fd = 0, n_se = 0, pix_out = 0, rdy_viol = 0, stab_viol = 0;
  bit          m_hunt = 1'b1;
  int unsigned m_exp = 0, m_frames = 0, m_seq = 0, m_disc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Builds one packet's words and applies the sequence rules to it at packet level.
  task automatic send_pkt(input logic [15:0] id, input bit rnd, input bit model_on);
    logic [15:0] px[LP];
    int unsigned pn;
    pn = int'(id[11:0]);
    for (int i = 0; i < LP; i++) px[i] = rnd ? 16'($urandom) : 16'(pn * LP + i);
    src_q.push_back({16'h0000, id[7:0], id[15:8]});
    for (int k = 0; k < LP / 2; k++)
      src_q.push_back({px[2*k+1][7:0], px[2*k+1][15:8], px[2*k][7:0], px[2*k][15:8]});
    if (model_on) begin
      if (id[11:8] == 4'hF) begin
        m_disc++;
      end else begin
        if (m_hunt && pn == 0) begin
          m_hunt = 1'b0;
          m_exp  = 0;
        end
        if (!m_hunt) begin
          if (pn == m_exp) begin
            for (int i = 0; i < LP; i++)
              exp_q.push_back({(pn == 0 && i == 0), (i == LP - 1), px[i]});
            m_exp++;
            if (m_exp == FL) begin
              m_frames++;
              m_exp = 0;
            end
          end else begin
            m_seq++;
            m_hunt = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic send_frame(input bit rnd);
    for (int p = 0; p < FL; p++) send_pkt(16'(p), rnd, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    src_q.delete();
    exp_q.delete();
    m_hunt = 1'b1; m_exp = 0; m_frames = 0; m_seq = 0; m_disc = 0;
    n_fd = 0; n_se = 0; pix_out = 0; rdy_viol = 0; stab_viol = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 40000) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(posedge clk);
    check({tag, "_drain"}, 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_frame_done"}, n_fd, m_frames);
    check({tag, "_seq_err"}, n_se, m_seq);
    check({tag, "_discard_cnt"}, {16'h0, discard_cnt}, m_disc);
    check({tag, "_ready_full"}, rdy_viol, 32'd0);
    check({tag, "_stable"}, stab_viol, 32'd0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_tvalid"}, {31'h0, m_axis_tvalid}, 32'd0);
    check({tag, "_tlast"}, {31'h0, m_axis_tlast}, 32'd0);
    check({tag, "_tuser"}, {31'h0, m_axis_tuser}, 32'd0);
    check({tag, "_tdata"}, {16'h0, m_axis_tdata}, 32'd0);
    check({tag, "_frame_done"}, {31'h0, frame_done}, 32'd0);
    check({tag, "_seq_err"}, {31'h0, seq_err}, 32'd0);
    check({tag, "_discard_cnt"}, {16'h0, discard_cnt}, 32'd0);
    check({tag, "_line_num"}, {26'h0, line_num}, 32'd0);
    check({tag, "_s_tready"}, {31'h0, s_axis_tready}, 32'd0);
  endtask

  // Source driver, sink handshake and output monitor in one cycle loop.
  initial begin : engine
    bit          s_fire = 1'b0, m_fire = 1'b0, stall_prev = 1'b0;
    logic [15:0] prev_data = '0;
    int unsigned phase = 0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_axis_tvalid = 1'b0;
        s_fire = 1'b0;
      end else begin
        if (s_fire && src_q.size() > 0) void'(src_q.pop_front());
        if (!s_axis_tvalid || s_fire) begin
          if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src_q[0];
          end else begin
            s_axis_tvalid = 1'b0;
          end
        end
      end
      case (tmode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = 1'($urandom_range(1));
        default: m_axis_tready = (phase % 3 == 0);
      endcase
      phase++;
      @(negedge clk);
      if (!rst_n) begin
        s_fire = 1'b0;
        stall_prev = 1'b0;
      end else begin
        s_fire = s_axis_tvalid && s_axis_tready;
        m_fire = m_axis_tvalid && m_axis_tready;
        if (stall_prev && !(m_axis_tvalid && m_axis_tdata == prev_data)) stab_viol++;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        if (s_axis_tready && m_axis_tvalid && !m_axis_tready) rdy_viol++;
        if (frame_done) n_fd++;
        if (seq_err) n_se++;
        if (m_fire) begin
          pix_out++;
          if (exp_q.size() == 0) check("extra_pixel", 32'(exp_q.size()), 32'd1);
          else check("pixel", {14'h0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {14'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin : main
    // Reset state
    repeat (2) @(posedge clk);
    #2 reset_outputs("reset");
    do_reset();

    // In-order frame, pixel value = line*80+index, sink always ready
    tmode = 0; gap_pct = 20;
    send_frame(1'b0);
    drain("pass");
    end_checks("pass");

    // Discard packets between lines 9 and 10
    do_reset();
    tmode = 1;
    for (int p = 0; p < 10; p++) send_pkt(16'(p), 1'b1, 1'b1);
    for (int d = 0; d < 3; d++) send_pkt(16'h0F00, 1'b1, 1'b1);
    for (int p = 10; p < FL; p++) send_pkt(16'(p), 1'b1, 1'b1);
    drain("discard");
    end_checks("discard");

    // Sequence error: 0..4 then 7, resync on the next frame
    do_reset();
    tmode = 0;
    for (int p = 0; p < 5; p++) send_pkt(16'(p), 1'b1, 1'b1);
    for (int p = 7; p < 10; p++) send_pkt(16'(p), 1'b1, 1'b1);
    send_frame(1'b1);
    drain("seqerr");
    end_checks("seqerr");

    // Sink ready one cycle in three
    do_reset();
    tmode = 2; gap_pct = 10;
    send_frame(1'b1);
    drain("bp");
    end_checks("bp");

    // Asynchronous reset at pixel 37 of line 20
    do_reset();
    tmode = 1;
    send_frame(1'b1);
    begin
      int unsigned n = 0;
      while (pix_out < 20 * LP + 37 && n < 30000) begin
        @(posedge clk);
        n++;
      end
    end
    check("rst_reached", 32'(pix_out >= 20 * LP + 37), 32'd1);
    #3 rst_n = 1'b0;
    #1 reset_outputs("midrst");

    // Enable low from line 30 to line 40, resume on the next frame
    do_reset();
    tmode = 0; gap_pct = 20;
    for (int p = 0; p < 30; p++) send_pkt(16'(p), 1'b1, 1'b1);
    drain("en_a");
    en = 1'b0;
    m_hunt = 1'b1;
    for (int p = 30; p < 40; p++) send_pkt(16'(p), 1'b1, 1'b0);
    drain("en_b");
    en = 1'b1;
    for (int p = 40; p < FL; p++) send_pkt(16'(p), 1'b1, 1'b1);
    send_frame(1'b1);
    drain("en_c");
    end_checks("en");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
